ebi_bridge: RTL and testbench

EBI_BRIDGE -- requirements
Module: ebi_bridge

---
 rtl/ebi_bridge.sv | 193 +++++++++++++++++++
 tb/tb_ebi_bridge.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebi_bridge.sv
// ebi_bridge: MCU external-bus (EBI) slave to on-chip write FIFO bridge.
// Strobes and AD are synchronised into clk; ALE rising latches the address,
// WE rising pushes {address, data} into a first-word fall-through FIFO.
// Ports:
//   clk, reset          - single clock, synchronous active-low reset
//   EBI_AD/ALE/WE/RE    - asynchronous MCU bus (strobes active-low)
//   wr_addr/data/valid  - FIFO head towards consumer, wr_ready pops it
//   fill_level          - entries held, overflow sticky drop flag
//   overflow_clr        - clears overflow (a new drop in same cycle wins)
//   rd_req/rd_addr/rd_data/rd_valid/EBI_AD_out/EBI_AD_oe - read path,
//                         present only with `define EBI_BRIDGE_READ_EN
module ebi_bridge #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             EBI_AD,
    input  logic                          EBI_ALE,
    input  logic                          EBI_WE,
    input  logic                          EBI_RE,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [DATA_W-1:0]             wr_data,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    input  logic                          overflow_clr
`ifdef EBI_BRIDGE_READ_EN
    ,
    output logic                          rd_req,
    output logic [ADDR_W-1:0]             rd_addr,
    input  logic [DATA_W-1:0]             rd_data,
    input  logic                          rd_valid,
    output logic [DATA_W-1:0]             EBI_AD_out,
    output logic                          EBI_AD_oe
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + DATA_W;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0]             ale_sync_q, we_sync_q;
    logic                               ale_hist_q, we_hist_q;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] ad_sync_q;
    logic [DATA_W-1:0]                  ad_hist_q;
    logic                               ale_rise, we_rise;

    // Synchronisers reset high so releasing reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ale_sync_q <= '1;
            we_sync_q  <= '1;
            ale_hist_q <= 1'b1;
            we_hist_q  <= 1'b1;
            ad_sync_q  <= '1;
            ad_hist_q  <= '1;
        end else begin
            ale_sync_q <= {ale_sync_q[SYNC_STAGES-2:0], EBI_ALE};
            we_sync_q  <= {we_sync_q[SYNC_STAGES-2:0], EBI_WE};
            ale_hist_q <= ale_sync_q[SYNC_STAGES-1];
            we_hist_q  <= we_sync_q[SYNC_STAGES-1];
            ad_sync_q  <= {ad_sync_q[SYNC_STAGES-2:0], EBI_AD};
            ad_hist_q  <= ad_sync_q[SYNC_STAGES-1];
        end
    end

    assign ale_rise = ale_sync_q[SYNC_STAGES-1] & ~ale_hist_q;
    assign we_rise  = we_sync_q[SYNC_STAGES-1] & ~we_hist_q;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              full, pop, push, drop;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];

    // The history stage holds AD as sampled while the strobe was still low.
    // A same-cycle ALE edge feeds addr_d straight into the pushed entry.
    always_comb begin
        addr_d  = addr_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        full    = (count_q == FULL_CNT);
        pop     = wr_valid && wr_ready;
        push    = we_rise && (!full || pop);
        drop    = we_rise && full && !pop;
        if (ale_rise) addr_d = ad_hist_q[ADDR_W-1:0];
        if (push) wptr_d = wptr_q + PW'(1);
        if (pop) rptr_d = rptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
        if (drop) ovf_d = 1'b1;
        else if (overflow_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) mem_q[wptr_q] <= {addr_d, ad_hist_q};
    end

    // Head is forced to zero when empty so stale storage never shows.
    assign wr_valid   = (count_q != '0);
    assign {wr_addr, wr_data} = wr_valid ? mem_q[rptr_q] : '0;
    assign fill_level = count_q;
    assign overflow   = ovf_q;

`ifdef EBI_BRIDGE_READ_EN
    typedef enum logic [1:0] {
        RD_IDLE, RD_PEND, RD_WAIT, RD_DRIVE
    } rd_state_e;

    rd_state_e              rd_state_q, rd_state_d;
    logic [SYNC_STAGES-1:0] re_sync_q;
    logic                   re_hist_q, re_fall, re_rise;
    logic [DATA_W-1:0]      ad_out_q, ad_out_d;
    logic                   oe_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            re_sync_q  <= '1;
            re_hist_q  <= 1'b1;
            rd_state_q <= RD_IDLE;
            ad_out_q   <= '0;
            oe_q       <= 1'b0;
        end else begin
            re_sync_q  <= {re_sync_q[SYNC_STAGES-2:0], EBI_RE};
            re_hist_q  <= re_sync_q[SYNC_STAGES-1];
            rd_state_q <= rd_state_d;
            ad_out_q   <= ad_out_d;
            oe_q       <= (rd_state_d == RD_DRIVE);
        end
    end

    assign re_fall = ~re_sync_q[SYNC_STAGES-1] & re_hist_q;
    assign re_rise = re_sync_q[SYNC_STAGES-1] & ~re_hist_q;

    // Read issues only once the write buffer is empty; RE released early
    // abandons the read from any state.
    always_comb begin
        rd_state_d = rd_state_q;
        ad_out_d   = ad_out_q;
        rd_req     = 1'b0;
        unique case (rd_state_q)
            RD_IDLE:  if (re_fall) rd_state_d = RD_PEND;
            RD_PEND: begin
                if (re_rise) rd_state_d = RD_IDLE;
                else if (count_q == '0) begin
                    rd_req     = 1'b1;
                    rd_state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (re_rise) rd_state_d = RD_IDLE;
                else if (rd_valid) begin
                    ad_out_d   = rd_data;
                    rd_state_d = RD_DRIVE;
                end
            end
            RD_DRIVE: if (re_rise) rd_state_d = RD_IDLE;
            default:  rd_state_d = RD_IDLE;
        endcase
    end

    assign rd_addr    = addr_q;
    assign EBI_AD_out = ad_out_q;
    assign EBI_AD_oe  = oe_q;
`else
    logic unused_re;
    assign unused_re = EBI_RE;
`endif

endmodule

// File: tb/tb_ebi_bridge.sv
// tb_ebi_bridge: randomized self-checking bench for ebi_bridge.
// Queue-based reference model of the write buffer and overflow flag.
module tb_ebi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] EBI_AD;
    logic        EBI_ALE, EBI_WE, EBI_RE;
    logic [15:0] wr_addr, wr_data;
    logic        wr_valid, wr_ready;
    logic [3:0]  fill_level;
    logic        overflow, overflow_clr;
`ifdef EBI_BRIDGE_READ_EN
    logic        rd_req, rd_valid, EBI_AD_oe;
    logic [15:0] rd_addr, rd_data, EBI_AD_out;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    ebi_bridge dut (
        .clk(clk), .reset(reset),
        .EBI_AD(EBI_AD), .EBI_ALE(EBI_ALE),
        .EBI_WE(EBI_WE), .EBI_RE(EBI_RE),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .fill_level(fill_level), .overflow(overflow),
        .overflow_clr(overflow_clr)
`ifdef EBI_BRIDGE_READ_EN
        ,
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .EBI_AD_out(EBI_AD_out), .EBI_AD_oe(EBI_AD_oe)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic ale_cycle(input logic [15:0] a);
        @(negedge clk);
        EBI_AD = a; EBI_ALE = 1'b0;
        repeat (3) @(negedge clk);
        EBI_ALE = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic we_low(input logic [15:0] d);
        @(negedge clk);
        EBI_AD = d; EBI_WE = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        ale_cycle(a);
        we_low(d);
        EBI_WE = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    // Drain the FIFO comparing every beat against the model queue.
    task automatic drain(input string nm);
        int n;
        n = exp_q.size();
        wr_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (wr_valid !== 1'b1 || {wr_addr, wr_data} !== exp_q[0]) begin
                errors++;
                $display("FAIL %s beat %0d got v=%b %h want %h",
                         nm, i, wr_valid, {wr_addr, wr_data}, exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        wr_ready = 1'b0;
        checks++;
        if (wr_valid !== 1'b0 || fill_level !== 4'd0) begin
            errors++;
            $display("FAIL %s empty got v=%b fill=%0d want 0/0",
                     nm, wr_valid, fill_level);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (wr_valid !== 1'b0 || fill_level !== 4'd0 || overflow !== 1'b0 ||
            wr_addr !== 16'h0 || wr_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got v=%b f=%0d o=%b a=%h d=%h want 0",
                     wr_valid, fill_level, overflow, wr_addr, wr_data);
        end
`ifdef EBI_BRIDGE_READ_EN
        checks++;
        if (rd_req !== 1'b0 || EBI_AD_oe !== 1'b0 || EBI_AD_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_read got req=%b oe=%b out=%h want 0",
                     rd_req, EBI_AD_oe, EBI_AD_out);
        end
`endif
    endtask

    task automatic test_latency();
        wr_ready = 1'b0;
        ale_cycle(16'h1234);
        we_low(16'hBEEF);
        EBI_WE = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got %b want 0", wr_valid);
        end
        @(negedge clk);
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 16'h1234 ||
            wr_data !== 16'hBEEF || fill_level !== 4'd1) begin
            errors++;
            $display("FAIL latency_beat got v=%b a=%h d=%h f=%0d want 1/1234/beef/1",
                     wr_valid, wr_addr, wr_data, fill_level);
        end
        exp_q.push_back({16'h1234, 16'hBEEF});
        drain("latency_pop");
    endtask

    task automatic test_same_edge();
        logic [15:0] v;
        v = 16'($urandom);
        @(negedge clk);
        EBI_AD = v; EBI_ALE = 1'b0; EBI_WE = 1'b0;
        repeat (3) @(negedge clk);
        EBI_ALE = 1'b1; EBI_WE = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back({v, v});
        drain("same_edge");
    endtask

    task automatic test_random();
        bit done = 1'b0;
        bit ok = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [15:0] a, d;
                    a = 16'($urandom);
                    d = 16'($urandom);
                    exp_q.push_back({a, d});
                    bus_write(a, d);
                end
                done = 1'b1;
            end
            begin
                for (int c = 0; c < 3000 && !ok; c++) begin
                    @(negedge clk);
                    wr_ready = 1'($urandom_range(0, 1));
                    if (wr_valid && wr_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL random_extra got %h want none",
                                     {wr_addr, wr_data});
                        end else begin
                            if ({wr_addr, wr_data} !== exp_q[0]) begin
                                errors++;
                                $display("FAIL random_beat got %h want %h",
                                         {wr_addr, wr_data}, exp_q[0]);
                            end
                            void'(exp_q.pop_front());
                        end
                    end
                    if (done && exp_q.size() == 0 && !wr_valid) ok = 1'b1;
                end
            end
        join
        wr_ready = 1'b0;
        checks++;
        if (!ok || overflow !== 1'b0) begin
            errors++;
            $display("FAIL random_done got ok=%b ovf=%b want 1/0", ok, overflow);
        end
    endtask

    task automatic fill8();
        wr_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] a, d;
            a = 16'($urandom);
            d = 16'($urandom);
            exp_q.push_back({a, d});
            bus_write(a, d);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        fill8();
        bus_write(16'hDEAD, 16'h0009);
        checks++;
        if (fill_level !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_full got f=%0d o=%b want 8/1",
                     fill_level, overflow);
        end
        drain("overflow_drain");
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky got %b want 1", overflow);
        end
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clr got %b want 0", overflow);
        end
    endtask

    task automatic test_full_pop();
        logic [15:0] a, d;
        do_reset();
        fill8();
        a = 16'($urandom);
        d = 16'($urandom);
        ale_cycle(a);
        we_low(d);
        EBI_WE = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({a, d});
        checks++;
        if (fill_level !== 4'd8 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pop got f=%0d o=%b want 8/0",
                     fill_level, overflow);
        end
        repeat (2) @(negedge clk);
        drain("full_pop_drain");
    endtask

    task automatic test_ovf_clr();
        do_reset();
        fill8();
        bus_write(16'h1111, 16'h2222);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL clr_pre got %b want 1", overflow);
        end
        ale_cycle(16'h3333);
        we_low(16'h4444);
        EBI_WE = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_set got %b want 1", overflow);
        end
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0 || fill_level !== 4'd8) begin
            errors++;
            $display("FAIL clr_alone got o=%b f=%0d want 0/8",
                     overflow, fill_level);
        end
    endtask

    task automatic test_reset_backlog();
        logic [15:0] d;
        do_reset();
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(16'($urandom), 16'($urandom));
        checks++;
        if (fill_level !== 4'd3) begin
            errors++;
            $display("FAIL backlog got %0d want 3", fill_level);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_valid !== 1'b0 || fill_level !== 4'd0) begin
            errors++;
            $display("FAIL backlog_reset got v=%b f=%0d want 0/0",
                     wr_valid, fill_level);
        end
        reset = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (wr_valid !== 1'b0 || fill_level !== 4'd0) begin
            errors++;
            $display("FAIL release_push got v=%b f=%0d want 0/0",
                     wr_valid, fill_level);
        end
        d = 16'($urandom);
        we_low(d);
        EBI_WE = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back({16'h0000, d});
        drain("addr_cleared");
    endtask

`ifdef EBI_BRIDGE_READ_EN
    task automatic test_read();
        bit seen = 1'b0;
        bit got = 1'b0;
        do_reset();
        wr_ready = 1'b0;
        bus_write(16'h0010, 16'hAAAA);
        bus_write(16'h0020, 16'hBBBB);
        ale_cycle(16'h0040);
        @(negedge clk);
        EBI_RE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rd_req) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL read_before_drain got req=1 want 0");
        end
        wr_ready = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rd_req) got = 1'b1;
        end
        wr_ready = 1'b0;
        checks++;
        if (!got || fill_level !== 4'd0 || rd_addr !== 16'h0040) begin
            errors++;
            $display("FAIL read_req got req=%b f=%0d a=%h want 1/0/0040",
                     got, fill_level, rd_addr);
        end
        @(negedge clk);
        checks++;
        if (rd_req !== 1'b0) begin
            errors++;
            $display("FAIL read_pulse got %b want 0", rd_req);
        end
        rd_data = 16'h5A5A; rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0; rd_data = 16'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (EBI_AD_oe !== 1'b1 || EBI_AD_out !== 16'h5A5A) begin
            errors++;
            $display("FAIL read_drive got oe=%b out=%h want 1/5a5a",
                     EBI_AD_oe, EBI_AD_out);
        end
        EBI_RE = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (!EBI_AD_oe) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL read_release got oe=%b want 0", EBI_AD_oe);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        EBI_AD = '0; EBI_ALE = 1'b1; EBI_WE = 1'b1; EBI_RE = 1'b1;
        wr_ready = 1'b0; overflow_clr = 1'b0;
`ifdef EBI_BRIDGE_READ_EN
        rd_valid = 1'b0; rd_data = '0;
`endif
        test_reset();
        test_latency();
        test_same_edge();
        test_random();
        test_overflow();
        test_full_pop();
        test_ovf_clr();
        test_reset_backlog();
`ifdef EBI_BRIDGE_READ_EN
        test_read();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
